// File: rtl/reg_list_sequencer_pkg.sv
// Shared definitions for the register-list transfer sequencer.
//   WORD        : data / address width of the datapath
//   ADDR_WIDTH  : register file index width
//   seq_state_t : sequencer FSM states
package reg_list_sequencer_pkg;

  localparam int unsigned WORD       = 32;
  localparam int unsigned ADDR_WIDTH = 4;

  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_ISSUE,
    SEQ_DRAIN,
    SEQ_DONE
  } seq_state_t;

endpackage

// File: rtl/reg_list_sequencer_lowest_set_bit_enc.sv
// Combinational priority encoder: index of the lowest set bit of vec_i.
//   vec_i   : input bit vector
//   valid_o : 1 when any bit of vec_i is set
//   idx_o   : index of the lowest set bit (0 when vec_i is zero)
module lowest_set_bit_enc #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned IDX_W = 4
) (
  input  logic [WIDTH-1:0] vec_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] idx_o
);

  always_comb begin
    valid_o = |vec_i;
    idx_o   = '0;
    // Scan high-to-low so the lowest set bit is the last one to win.
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (vec_i[WIDTH-1-i]) begin
        idx_o = IDX_W'(WIDTH-1-i);
      end
    end
  end

endmodule

// File: rtl/reg_list_sequencer.sv
// Multi-register transfer controller for PUSH/POP/LDM/STM.
// Walks the register list lowest-to-highest, one register per cycle, issuing
// register-file reads (store) or memory reads (load), then completing each
// transfer one cycle later in a second stage.
//   clk_i, rst_i        : clock, synchronous active-high reset
//   start_i             : launch a transfer (sampled only in IDLE)
//   is_load_i           : 1 = memory -> registers, 0 = registers -> memory
//   dec_before_i        : 1 = decrement-before, 0 = increment-after
//   reg_list_i          : bit n set = transfer register n
//   base_addr_i         : base address
//   reg_rd_addr_o/reg_rd_data_i             : register file read port
//   reg_wr_en_o/reg_wr_addr_o/reg_wr_data_o : register file write port
//   mem_addr_o/mem_rd_en_o/mem_rd_data_i    : data memory read port
//   mem_wr_en_o/mem_wr_data_o               : data memory write port
//   busy_o      : high in any non-IDLE state
//   done_o      : one-cycle pulse at the end of a transfer
//   base_wb_o   : updated base address, valid while done_o is high
module reg_list_sequencer
  import reg_list_sequencer_pkg::*;
#(
  parameter int unsigned REG_NUM   = 16,
  parameter int unsigned ADDR_STEP = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  is_load_i,
  input  logic                  dec_before_i,
  input  logic [REG_NUM-1:0]    reg_list_i,
  input  logic [WORD-1:0]       base_addr_i,
  output logic [ADDR_WIDTH-1:0] reg_rd_addr_o,
  input  logic [WORD-1:0]       reg_rd_data_i,
  output logic                  reg_wr_en_o,
  output logic [ADDR_WIDTH-1:0] reg_wr_addr_o,
  output logic [WORD-1:0]       reg_wr_data_o,
  output logic [WORD-1:0]       mem_addr_o,
  output logic                  mem_rd_en_o,
  input  logic [WORD-1:0]       mem_rd_data_i,
  output logic                  mem_wr_en_o,
  output logic [WORD-1:0]       mem_wr_data_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [WORD-1:0]       base_wb_o
);

  seq_state_t            state_q,    state_d;
  logic [REG_NUM-1:0]    list_q,     list_d;
  logic                  is_load_q,  is_load_d;
  logic [WORD-1:0]       cur_addr_q, cur_addr_d;
  logic [WORD-1:0]       base_wb_q,  base_wb_d;
  logic                  s2_valid_q, s2_valid_d;
  logic [ADDR_WIDTH-1:0] s2_idx_q,   s2_idx_d;
  logic [WORD-1:0]       s2_addr_q,  s2_addr_d;

  logic [WORD-1:0]       pop_cnt;
  logic [WORD-1:0]       span;
  logic                  k_valid;
  logic [ADDR_WIDTH-1:0] k_idx;
  logic [REG_NUM-1:0]    k_mask;
  logic [REG_NUM-1:0]    list_clr;

  lowest_set_bit_enc #(
    .WIDTH (REG_NUM),
    .IDX_W (ADDR_WIDTH)
  ) u_lsb (
    .vec_i   (list_q),
    .valid_o (k_valid),
    .idx_o   (k_idx)
  );

  // Number of registers in the incoming list and the byte span it covers.
  always_comb begin
    pop_cnt = '0;
    for (int unsigned i = 0; i < REG_NUM; i++) begin
      pop_cnt = pop_cnt + WORD'(reg_list_i[i]);
    end
    span = WORD'(ADDR_STEP) * pop_cnt;
  end

  always_comb begin
    k_mask        = '0;
    k_mask[k_idx] = 1'b1;
    list_clr      = list_q & ~k_mask;
  end

  always_comb begin
    state_d    = state_q;
    list_d     = list_q;
    is_load_d  = is_load_q;
    cur_addr_d = cur_addr_q;
    base_wb_d  = base_wb_q;
    s2_valid_d = 1'b0;
    s2_idx_d   = s2_idx_q;
    s2_addr_d  = s2_addr_q;

    reg_rd_addr_o = '0;
    reg_wr_en_o   = 1'b0;
    reg_wr_addr_o = '0;
    reg_wr_data_o = '0;
    mem_addr_o    = '0;
    mem_rd_en_o   = 1'b0;
    mem_wr_en_o   = 1'b0;
    mem_wr_data_o = '0;
    done_o        = 1'b0;
    base_wb_o     = '0;
    busy_o        = (state_q != SEQ_IDLE);

    // Stage 2 completes the transfer issued in the previous cycle. It can
    // overlap an issue: for loads the issue owns mem_addr_o (read) while
    // stage 2 writes the register file; for stores stage 2 owns mem_addr_o
    // (write) while the issue only drives the register read address.
    if (s2_valid_q) begin
      if (is_load_q) begin
        reg_wr_en_o   = 1'b1;
        reg_wr_addr_o = s2_idx_q;
        reg_wr_data_o = mem_rd_data_i;
      end else begin
        mem_wr_en_o   = 1'b1;
        mem_addr_o    = s2_addr_q;
        mem_wr_data_o = reg_rd_data_i;
      end
    end

    unique case (state_q)
      SEQ_IDLE: begin
        if (start_i) begin
          list_d     = reg_list_i;
          is_load_d  = is_load_i;
          cur_addr_d = dec_before_i ? (base_addr_i - span) : base_addr_i;
          base_wb_d  = dec_before_i ? (base_addr_i - span)
                                    : (base_addr_i + span);
          state_d    = (|reg_list_i) ? SEQ_ISSUE : SEQ_DONE;
        end
      end

      SEQ_ISSUE: begin
        if (is_load_q) begin
          mem_rd_en_o = 1'b1;
          mem_addr_o  = cur_addr_q;
        end else begin
          reg_rd_addr_o = k_idx;
        end
        list_d     = list_clr;
        cur_addr_d = cur_addr_q + WORD'(ADDR_STEP);
        s2_valid_d = k_valid;
        s2_idx_d   = k_idx;
        s2_addr_d  = cur_addr_q;
        if (list_clr == '0) begin
          state_d = SEQ_DRAIN;
        end
      end

      SEQ_DRAIN: begin
        state_d = SEQ_DONE;
      end

      SEQ_DONE: begin
        done_o    = 1'b1;
        base_wb_o = base_wb_q;
        state_d   = SEQ_IDLE;
      end

      default: begin
        state_d = SEQ_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= SEQ_IDLE;
      list_q     <= '0;
      is_load_q  <= 1'b0;
      cur_addr_q <= '0;
      base_wb_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_idx_q   <= '0;
      s2_addr_q  <= '0;
    end else begin
      state_q    <= state_d;
      list_q     <= list_d;
      is_load_q  <= is_load_d;
      cur_addr_q <= cur_addr_d;
      base_wb_q  <= base_wb_d;
      s2_valid_q <= s2_valid_d;
      s2_idx_q   <= s2_idx_d;
      s2_addr_q  <= s2_addr_d;
    end
  end

endmodule

// File: tb/tb_reg_list_sequencer.sv
// Self-checking bench for reg_list_sequencer: a table of directed transfers
// followed by randomized transfers, each checked cycle by cycle against a
// transfer-level timing model.
module tb_reg_list_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic        is_load_i;
  logic        dec_before_i;
  logic [15:0] reg_list_i;
  logic [31:0] base_addr_i;
  logic [3:0]  reg_rd_addr_o;
  logic [31:0] reg_rd_data_i;
  logic        reg_wr_en_o;
  logic [3:0]  reg_wr_addr_o;
  logic [31:0] reg_wr_data_o;
  logic [31:0] mem_addr_o;
  logic        mem_rd_en_o;
  logic [31:0] mem_rd_data_i;
  logic        mem_wr_en_o;
  logic [31:0] mem_wr_data_o;
  logic        busy_o;
  logic        done_o;
  logic [31:0] base_wb_o;

  int total = 0;
  int bad   = 0;

  reg_list_sequencer #(
    .REG_NUM   (16),
    .ADDR_STEP (4)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .start_i       (start_i),
    .is_load_i     (is_load_i),
    .dec_before_i  (dec_before_i),
    .reg_list_i    (reg_list_i),
    .base_addr_i   (base_addr_i),
    .reg_rd_addr_o (reg_rd_addr_o),
    .reg_rd_data_i (reg_rd_data_i),
    .reg_wr_en_o   (reg_wr_en_o),
    .reg_wr_addr_o (reg_wr_addr_o),
    .reg_wr_data_o (reg_wr_data_o),
    .mem_addr_o    (mem_addr_o),
    .mem_rd_en_o   (mem_rd_en_o),
    .mem_rd_data_i (mem_rd_data_i),
    .mem_wr_en_o   (mem_wr_en_o),
    .mem_wr_data_o (mem_wr_data_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .base_wb_o     (base_wb_o)
  );

  always #5 clk_i = ~clk_i;

  // Content of register k and of memory word a, as fixed patterns.
  function automatic logic [31:0] reg_val(input int k);
    return 32'hC0DE_0000 | (32'(k) * 32'h111);
  endfunction

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return (a ^ 32'h5A5A_3C3C) + 32'h0001_0001;
  endfunction

  // Register file with 1-cycle registered read; memory with 1-cycle read.
  always @(posedge clk_i) begin
    reg_rd_data_i <= reg_val(int'(reg_rd_addr_o));
    mem_rd_data_i <= mem_rd_en_o ? mem_val(mem_addr_o) : 32'h0;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Runs one transfer starting in the current cycle (called #1 after a
  // posedge). Inputs are scrambled after the start cycle; optionally start_i
  // is pulsed again in cycle 2, or rst_i is asserted in cycle rst_at.
  task automatic run_xfer(input logic ld, input logic dec, input logic [15:0] list,
                          input logic [31:0] base, input bit restart, input int rst_at,
                          output logic [31:0] cap_wb, output logic [31:0] cap_a0);
    int          idx[$];
    int          n;
    int          last_c;
    int          j;
    logic [31:0] first;
    logic [31:0] wb;
    bit          alive, e_busy, e_done, e_mrd, e_rrd, e_s2;

    for (int i = 0; i < 16; i++) if (list[i]) idx.push_back(i);
    n      = idx.size();
    first  = dec ? base - 32'(4 * n) : base;
    wb     = dec ? base - 32'(4 * n) : base + 32'(4 * n);
    last_c = (n == 0) ? 1 : n + 2;
    cap_wb = '0;
    cap_a0 = '0;

    is_load_i    = ld;
    dec_before_i = dec;
    reg_list_i   = list;
    base_addr_i  = base;
    start_i      = 1'b1;
    @(posedge clk_i);
    #1;

    for (int c = 1; c <= last_c + 1; c++) begin
      rst_i        = (rst_at == c);
      start_i      = restart && (c == 2) && (n > 0);
      is_load_i    = 1'($urandom);
      dec_before_i = 1'($urandom);
      reg_list_i   = 16'($urandom);
      base_addr_i  = $urandom;
      @(negedge clk_i);

      alive  = (rst_at == 0) || (c <= rst_at);
      e_busy = alive && (c <= last_c);
      e_done = alive && (c == last_c);
      e_mrd  = alive && ld && (c <= n);
      e_rrd  = alive && !ld && (c <= n);
      e_s2   = alive && (c >= 2) && (c <= n + 1);

      chk("busy", 32'(busy_o), 32'(e_busy));
      chk("done", 32'(done_o), 32'(e_done));
      chk("mem_rd_en", 32'(mem_rd_en_o), 32'(e_mrd));
      chk("mem_wr_en", 32'(mem_wr_en_o), 32'(e_s2 && !ld));
      chk("reg_wr_en", 32'(reg_wr_en_o), 32'(e_s2 && ld));

      if (e_mrd) begin
        chk("mem_rd_addr", mem_addr_o, first + 32'(4 * (c - 1)));
        if (c == 1) cap_a0 = mem_addr_o;
      end
      if (e_rrd) chk("reg_rd_addr", 32'(reg_rd_addr_o), 32'(idx[c-1]));
      if (e_s2) begin
        j = c - 2;
        if (ld) begin
          chk("reg_wr_addr", 32'(reg_wr_addr_o), 32'(idx[j]));
          chk("reg_wr_data", reg_wr_data_o, mem_val(first + 32'(4 * j)));
        end else begin
          chk("mem_wr_addr", mem_addr_o, first + 32'(4 * j));
          chk("mem_wr_data", mem_wr_data_o, reg_val(idx[j]));
          if (c == 2) cap_a0 = mem_addr_o;
        end
      end
      if (e_done) begin
        chk("base_wb", base_wb_o, wb);
        cap_wb = base_wb_o;
      end

      @(posedge clk_i);
      #1;
    end
    rst_i   = 1'b0;
    start_i = 1'b0;
  endtask

  typedef struct {
    logic        ld;
    logic        dec;
    logic [15:0] list;
    logic [31:0] base;
    bit          restart;
    int          rst_at;
    bit          chk_wb;
    logic [31:0] exp_wb;
    bit          chk_a0;
    logic [31:0] exp_a0;
  } vec_t;

  vec_t tbl[8];

  initial begin
    logic [31:0] cap_wb, cap_a0;
    logic [15:0] list;
    logic        ld, dec;
    bit          restart;
    int          n, rst_at;

    tbl[0] = '{1'b0, 1'b0, 16'h0015, 32'h0000_0100, 1'b0, 0, 1'b1, 32'h0000_010C, 1'b1, 32'h0000_0100};
    tbl[1] = '{1'b1, 1'b1, 16'h8003, 32'h0000_0200, 1'b0, 0, 1'b1, 32'h0000_01F4, 1'b1, 32'h0000_01F4};
    tbl[2] = '{1'b0, 1'b0, 16'h0000, 32'h0000_0040, 1'b0, 0, 1'b1, 32'h0000_0040, 1'b0, 32'h0};
    tbl[3] = '{1'b0, 1'b0, 16'h0015, 32'h0000_0100, 1'b1, 0, 1'b1, 32'h0000_010C, 1'b1, 32'h0000_0100};
    tbl[4] = '{1'b0, 1'b0, 16'h00FF, 32'h0000_0300, 1'b0, 2, 1'b0, 32'h0,         1'b1, 32'h0000_0300};
    tbl[5] = '{1'b0, 1'b0, 16'h0003, 32'hFFFF_FFFC, 1'b0, 0, 1'b1, 32'h0000_0004, 1'b1, 32'hFFFF_FFFC};
    tbl[6] = '{1'b1, 1'b0, 16'hFFFF, 32'h0000_0000, 1'b0, 0, 1'b1, 32'h0000_0040, 1'b1, 32'h0000_0000};
    tbl[7] = '{1'b0, 1'b1, 16'h8000, 32'h0000_0010, 1'b0, 0, 1'b1, 32'h0000_000C, 1'b1, 32'h0000_000C};

    rst_i        = 1'b1;
    start_i      = 1'b0;
    is_load_i    = 1'b0;
    dec_before_i = 1'b0;
    reg_list_i   = '0;
    base_addr_i  = '0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("rst_busy", 32'(busy_o), 32'h0);
    chk("rst_done", 32'(done_o), 32'h0);
    chk("rst_strobes", {29'h0, mem_rd_en_o, mem_wr_en_o, reg_wr_en_o}, 32'h0);
    chk("rst_mem_addr", mem_addr_o, 32'h0);
    chk("rst_reg_rd_addr", 32'(reg_rd_addr_o), 32'h0);
    chk("rst_wr_data", reg_wr_data_o | mem_wr_data_o, 32'h0);
    chk("rst_base_wb", base_wb_o, 32'h0);
    @(posedge clk_i);
    #1;

    for (int t = 0; t < 8; t++) begin
      run_xfer(tbl[t].ld, tbl[t].dec, tbl[t].list, tbl[t].base,
               tbl[t].restart, tbl[t].rst_at, cap_wb, cap_a0);
      if (tbl[t].chk_wb) chk($sformatf("tbl%0d_base_wb", t), cap_wb, tbl[t].exp_wb);
      if (tbl[t].chk_a0) chk($sformatf("tbl%0d_first_addr", t), cap_a0, tbl[t].exp_a0);
    end

    for (int r = 0; r < 60; r++) begin
      list = 16'($urandom);
      if ($urandom_range(0, 2) == 0) list = list & 16'($urandom);
      if ($urandom_range(0, 9) == 0) list = '0;
      ld      = 1'($urandom);
      dec     = 1'($urandom);
      n       = $countones(list);
      rst_at  = 0;
      restart = ($urandom_range(0, 3) == 0);
      if (n > 0 && $urandom_range(0, 6) == 0) begin
        rst_at  = $urandom_range(1, n + 2);
        restart = 1'b0;
      end
      run_xfer(ld, dec, list, $urandom, restart, rst_at, cap_wb, cap_a0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
